// File: rtl/playback_mixer.sv
// -----------------------------------------------------------------------------
// playback_mixer
//
// Cross-fades between the live (filtered) audio path and the recorder playback
// path, one step per output-sample event, and drives the mixed stereo sample to
// the DAC with a fixed two-cycle latency.
//
// Ports
//   Clk          in   1   system clock, all logic on the rising edge
//   Reset        in   1   synchronous, active-high
//   SAMPLE_CLK   in   1   driver data_over level; each rising edge = one event
//   LIVE_DATA    in  32   live sample    {left[31:16], right[15:0]}, signed
//   REC_DATA     in  32   recorded sample, same format
//   DO_PLAYBACK  in   1   level, request recorded audio
//   MIX_EN       in   1   level, 50/50 blend while playing back
//   OUTPUT_DATA  out 32   mixed sample, held between OUT_VALID pulses
//   OUT_VALID    out  1   one-cycle pulse when OUTPUT_DATA updates
//   FADE_ACTIVE  out  1   high while the gain is ramping
//   GAIN         out  5   recorded-path gain g, 0..16
//   PEAK_L/R     out 15   peak meters, only with MIXER_PEAK_METER_EN defined
//
// Build option
//   MIXER_PEAK_METER_EN : adds PEAK_L / PEAK_R with slow decay every 256th
//                         event. Undefined by default (no peak logic at all).
//
// Pipeline
//   cycle E   : event detected, g stepped, samples and new g latched
//   cycle E+1 : lanes mix the latched samples, result registered at the edge
//   cycle E+2 : OUTPUT_DATA valid, OUT_VALID high for this one cycle
// -----------------------------------------------------------------------------

// One audio channel: out = (live*(16-g) + rec*g) >>> 4 in 21-bit signed.
// The weights sum to 16, so the result is a convex blend and always fits in
// 16 bits; bits [19:4] of the sum are exactly the arithmetic-shift result.
module playback_mixer_lane (
   input  logic [15:0] live_i,
   input  logic [15:0] rec_i,
   input  logic [4:0]  gain_i,
   output logic [15:0] mix_o
);
   logic signed [20:0] live_w;
   logic signed [20:0] rec_w;
   logic signed [20:0] wlive_w;
   logic signed [20:0] wrec_w;
   logic signed [20:0] sum_w;
   logic [4:0]         lane_unused;

   always_comb begin
      live_w  = {{5{live_i[15]}}, live_i};
      rec_w   = {{5{rec_i[15]}}, rec_i};
      // gain_i never exceeds 16, so 16-g stays in 0..16 and fits 5 bits
      wlive_w = {16'd0, 5'(5'd16 - gain_i)};
      wrec_w  = {16'd0, gain_i};
      sum_w   = live_w * wlive_w + rec_w * wrec_w;
      mix_o   = sum_w[19:4];
   end

   // sign-duplicate and fractional bits are dropped by the shift
   assign lane_unused = {sum_w[20], sum_w[3:0]};
endmodule

module playback_mixer (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        SAMPLE_CLK,
   input  logic [31:0] LIVE_DATA,
   input  logic [31:0] REC_DATA,
   input  logic        DO_PLAYBACK,
   input  logic        MIX_EN,
   output logic [31:0] OUTPUT_DATA,
   output logic        OUT_VALID,
   output logic        FADE_ACTIVE,
   output logic [4:0]  GAIN
`ifdef MIXER_PEAK_METER_EN
   ,
   output logic [14:0] PEAK_L,
   output logic [14:0] PEAK_R
`endif
);
   localparam int NUM_LANES = 2;   // lane 1 = left [31:16], lane 0 = right
   localparam int STAGES    = 1;   // vld_pipe_q[0]: latched, [STAGES]: output

   localparam logic [1:0] ST_LIVE   = 2'd0;
   localparam logic [1:0] ST_FADING = 2'd1;
   localparam logic [1:0] ST_STEADY = 2'd2;

   logic                            sclk_d,     sclk_q;
   logic [4:0]                      g_d,        g_q;
   logic [1:0]                      st_d,       st_q;
   logic [NUM_LANES-1:0][15:0]      live_d,     live_q;
   logic [NUM_LANES-1:0][15:0]      rec_d,      rec_q;
   logic [4:0]                      lat_g_d,    lat_g_q;
   logic [STAGES:0]                 vld_pipe_d, vld_pipe_q;
   logic [NUM_LANES-1:0][15:0]      out_d,      out_q;

   logic                            evt;
   logic [4:0]                      tgt;
   logic [NUM_LANES-1:0][15:0]      mix_w;

   // --------------------------------------------------------------------------
   // Per-channel blend
   // --------------------------------------------------------------------------
   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      playback_mixer_lane u_lane (
         .live_i (live_q[i]),
         .rec_i  (rec_q[i]),
         .gain_i (lat_g_q),
         .mix_o  (mix_w[i])
      );
   end

   // --------------------------------------------------------------------------
   // Event detection, gain ramp, state and sample latch
   // --------------------------------------------------------------------------
   always_comb begin
      // A held-high SAMPLE_CLK gives one event. An event in the cycle right
      // after another is dropped so the latch stage is never overwritten
      // before the lanes consume it.
      evt = SAMPLE_CLK & ~sclk_q & ~vld_pipe_q[0];

      if (!DO_PLAYBACK)  tgt = 5'd0;
      else if (MIX_EN)   tgt = 5'd8;
      else               tgt = 5'd16;

      sclk_d     = SAMPLE_CLK;
      g_d        = g_q;
      st_d       = st_q;
      live_d     = live_q;
      rec_d      = rec_q;
      lat_g_d    = lat_g_q;
      vld_pipe_d = {vld_pipe_q[STAGES-1:0], evt};
      out_d      = out_q;

      if (evt) begin
         // Step from wherever g is now, so a mid-fade target change simply
         // reverses or retargets without a jump.
         if (g_q < tgt)       g_d = g_q + 5'd1;
         else if (g_q > tgt)  g_d = g_q - 5'd1;

         if (g_d != tgt)      st_d = ST_FADING;
         else if (tgt == 5'd0) st_d = ST_LIVE;
         else                 st_d = ST_STEADY;

         live_d  = LIVE_DATA;
         rec_d   = REC_DATA;
         lat_g_d = g_d;
      end

      if (vld_pipe_q[0]) out_d = mix_w;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         sclk_q     <= 1'b0;
         g_q        <= 5'd0;
         st_q       <= ST_LIVE;
         live_q     <= '0;
         rec_q      <= '0;
         lat_g_q    <= 5'd0;
         vld_pipe_q <= '0;
         out_q      <= '0;
      end else begin
         sclk_q     <= sclk_d;
         g_q        <= g_d;
         st_q       <= st_d;
         live_q     <= live_d;
         rec_q      <= rec_d;
         lat_g_q    <= lat_g_d;
         vld_pipe_q <= vld_pipe_d;
         out_q      <= out_d;
      end
   end

   assign OUTPUT_DATA = out_q;
   assign OUT_VALID   = vld_pipe_q[STAGES];
   assign FADE_ACTIVE = (st_q == ST_FADING);
   assign GAIN        = g_q;

`ifdef MIXER_PEAK_METER_EN
   // --------------------------------------------------------------------------
   // Peak meters: track the largest |out| seen, decaying by 1/8 every 256th
   // event. When a decay and a new output land on the same edge the decay is
   // applied first so a fresh peak is never shaved.
   // --------------------------------------------------------------------------
   logic [NUM_LANES-1:0][14:0] peak_d, peak_q;
   logic [NUM_LANES-1:0][14:0] mag_w;
   logic [7:0]                 evt_cnt_d, evt_cnt_q;

   always_comb begin
      evt_cnt_d = evt ? evt_cnt_q + 8'd1 : evt_cnt_q;
      for (int i = 0; i < NUM_LANES; i++) begin
         // -32768 has no 16-bit magnitude; clamp it to full scale
         if (out_d[i] == 16'h8000)  mag_w[i] = 15'h7FFF;
         else if (out_d[i][15])     mag_w[i] = 15'(~out_d[i][14:0]) + 15'd1;
         else                       mag_w[i] = out_d[i][14:0];

         peak_d[i] = peak_q[i];
         if (evt && evt_cnt_q == 8'hFF)
            peak_d[i] = peak_q[i] - (peak_q[i] >> 3);
         if (vld_pipe_q[0] && mag_w[i] > peak_d[i])
            peak_d[i] = mag_w[i];
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         peak_q    <= '0;
         evt_cnt_q <= 8'd0;
      end else begin
         peak_q    <= peak_d;
         evt_cnt_q <= evt_cnt_d;
      end
   end

   assign PEAK_L = peak_q[1];
   assign PEAK_R = peak_q[0];
`endif

endmodule

// File: doc/playback_mixer.md
PLAYBACK_MIXER -- requirements
Module: playback_mixer

Interface
REQ-001 SHALL have port Clk  input  1  50 MHz system clock; all logic rising-edge.
REQ-002 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port SAMPLE_CLK  input  1  audio driver data_over level; each rising edge is one output-sample event.
REQ-004 SHALL have port LIVE_DATA  input  32  filtered live sample; [31:16] left, [15:0] right, signed two's complement.
REQ-005 SHALL have port REC_DATA  input  32  recorder playback sample, same format.
REQ-006 SHALL have port DO_PLAYBACK  input  1  level; high requests recorded audio.
REQ-007 SHALL have port MIX_EN  input  1  level; high blends live and recorded at 50/50 during playback instead of recorded only.
REQ-008 SHALL have port OUTPUT_DATA  output  32  mixed sample to DAC, same format.
REQ-009 SHALL have port OUT_VALID  output  1  one-cycle pulse when OUTPUT_DATA updates.
REQ-010 SHALL have port FADE_ACTIVE  output  1  high while gain is ramping.
REQ-011 SHALL have port GAIN  output  5  current recorded-path gain g, 0..16.

Function
REQ-012 SHALL detect event E as SAMPLE_CLK high while its one-cycle-delayed copy is low; a level held high yields exactly one event.
REQ-013 SHALL compute target T = 0 if DO_PLAYBACK low; 8 if DO_PLAYBACK and MIX_EN high; 16 otherwise, sampled at E.
REQ-014 SHALL step g at E: g+1 if g<T, g-1 if g>T, unchanged if equal; full fade is 16 events, half fade 8.
REQ-015 SHALL implement states LIVE (g=0, T=0), FADING (g!=T), STEADY (g=T>0); transitions evaluated at E only.
REQ-016 SHALL drive FADE_ACTIVE high exactly in FADING.
REQ-017 SHALL latch LIVE_DATA and REC_DATA at E, together with the g value after the step.
REQ-018 SHALL compute per channel out = (live*(16-g) + rec*g) >>> 4, using 21-bit signed intermediates and arithmetic shift (truncation toward negative infinity); the result always fits 16 bits and needs no saturation.
REQ-019 SHALL register OUTPUT_DATA and pulse OUT_VALID at cycle E+2; fixed 2-cycle latency.
REQ-020 SHALL, when DO_PLAYBACK or MIX_EN changes mid-fade, reverse or retarget from current g with no jump in g.
REQ-021 SHALL ignore an event arriving in E+1 (minimum event spacing 2 cycles); the pipeline is never overrun.
REQ-022 SHALL hold OUTPUT_DATA constant between OUT_VALID pulses.

Reset
REQ-023 SHALL, while Reset is high, set g=0, state LIVE, OUTPUT_DATA=0, OUT_VALID=0, FADE_ACTIVE=0, clear the edge detector and pipeline, and discard an in-flight sample.
REQ-024 SHALL give Reset priority over a coincident event; the first event is recognised no earlier than the cycle after Reset falls.

Configuration
REQ-025 SHALL, with macro MIXER_PEAK_METER_EN defined, add outputs PEAK_L and PEAK_R (output, 15 bits). At each OUT_VALID, each SHALL update to max(peak, |out|), with |-32768| clamped to 32767. Every 256th event, each SHALL decay by peak>>3. Both SHALL reset to 0.
REQ-026 SHALL, without MIXER_PEAK_METER_EN, omit PEAK_L/PEAK_R and all peak logic.

Verification
REQ-027 Reset, DO_PLAYBACK=0, LIVE=0x1000_F000, REC=0x7FFF_8000 -> output 0x1000_F000 at E+2 of each event; g=0; FADE_ACTIVE=0.
REQ-028 DO_PLAYBACK 0->1, MIX_EN=0 -> g counts 1..16 over 16 events; FADE_ACTIVE high until g=16; final output equals REC.
REQ-029 STEADY g=16, MIX_EN=1, LIVE left 0x0100, REC left 0x0300 -> after 8 events g=8, left out 0x0200.
REQ-030 Fading in at g=5, DO_PLAYBACK dropped -> g=4 at next event, reaches 0 at 5th event, state LIVE.
REQ-031 g=8, left live 0x8000, rec 0x8001 -> left out 0x8000; SAMPLE_CLK held high 10 cycles -> single OUT_VALID.
REQ-032 Reset asserted at cycle E+1 -> no OUT_VALID at E+2; OUTPUT_DATA=0; with MIXER_PEAK_METER_EN, PEAK_L=PEAK_R=0.
